bullet_lane_array: RTL and testbench

BULLET_LANE_ARRAY -- requirements
Module: bullet_lane_array

---
 rtl/starflux_pkg.sv | 20 ++
 rtl/bullet_lane.sv | 51 +++++
 rtl/bullet_tick_gen.sv | 34 +++
 rtl/bullet_lane_array.sv | 97 +++++++++
 tb/tb_bullet_lane_array.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/starflux_pkg.sv
// Shared constants for the bullet lane array: travel direction encoding,
// escaped-bullet counter width and its saturating accumulate helper.
package starflux_pkg;

    localparam bit SF_DIR_UP   = 1'b1;  // bullets travel toward row 0
    localparam bit SF_DIR_DOWN = 1'b0;  // bullets travel toward row DEPTH-1

    localparam int ESC_W = 8;
    localparam logic [ESC_W-1:0] ESC_MAX = '1;

    function automatic logic [ESC_W-1:0] esc_sat_add(
        input logic [ESC_W-1:0] acc,
        input int unsigned      inc
    );
        int unsigned sum;
        sum = 32'(acc) + inc;
        return (sum > 32'(ESC_MAX)) ? ESC_MAX : sum[ESC_W-1:0];
    endfunction

endpackage

// File: rtl/bullet_lane.sv
// One bullet column: optional hit clear, shift toward the exit on tick, then
// insert at the entry row. Hit clearing exists only with BULLET_HIT_CLEAR_EN.
module bullet_lane
    import starflux_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter bit DIR_UP = SF_DIR_UP
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tick,
    input  logic             insert,
`ifdef BULLET_HIT_CLEAR_EN
    input  logic [DEPTH-1:0] clr,
`endif
    output logic [DEPTH-1:0] col,
    output logic             dropped
);

    localparam int ENTRY = DIR_UP ? DEPTH - 1 : 0;
    localparam int EXIT  = DIR_UP ? 0 : DEPTH - 1;

    logic [DEPTH-1:0] cur;
    logic [DEPTH-1:0] nxt;

`ifdef BULLET_HIT_CLEAR_EN
    // Hit bullets vanish before they move, so they can never escape.
    assign cur = col & ~clr;
`else
    assign cur = col;
`endif

    assign dropped = tick & cur[EXIT];

    always_comb begin
        nxt = cur;
        if (tick)
            nxt = DIR_UP ? (cur >> 1) : (cur << 1);
        // Insertion after the shift keeps a same-cycle shot at the entry row.
        if (insert)
            nxt[ENTRY] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            col <= '0;
        else
            col <= nxt;
    end

endmodule

// File: rtl/bullet_tick_gen.sv
// Movement tick divider: counts TICK_DIV-1 down to 0 while enabled and emits
// a registered one-cycle tick on the wrap, so the first tick lands TICK_DIV cycles in.
module bullet_tick_gen #(
    parameter int TICK_DIV = 2500000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= RELOAD;
            tick <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (enable) begin
                if (cnt == '0) begin
                    cnt  <= RELOAD;
                    tick <= 1'b1;
                end else begin
                    cnt <= cnt - CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/bullet_lane_array.sv
// Array of independent bullet columns with fire handshake, cooldown and a
// saturating escape counter. Define BULLET_HIT_CLEAR_EN to add the hit_mask input.
module bullet_lane_array
    import starflux_pkg::*;
#(
    parameter int LANES    = 8,
    parameter int DEPTH    = 16,
    parameter bit DIR_UP   = SF_DIR_UP,
    parameter int TICK_DIV = 2500000,
    parameter int COOLDOWN = 3,
    // One bit wider than a lane index so out-of-range requests are expressible.
    localparam int LW = $clog2(LANES) + 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   fire,
    input  logic [LW-1:0]          fire_lane,
`ifdef BULLET_HIT_CLEAR_EN
    input  logic [LANES*DEPTH-1:0] hit_mask,
`endif
    output logic                   fire_ack,
    output logic                   fire_err,
    output logic                   tick,
    output logic [LANES*DEPTH-1:0] grid,
    output logic [ESC_W-1:0]       escaped_cnt
);

    localparam int CDW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam logic [CDW-1:0] CD_LOAD = CDW'(COOLDOWN);

    logic             lane_ok;
    logic             accept;
    logic             reject;
    logic [CDW-1:0]   cooldown;
    logic [LANES-1:0] ins;
    logic [LANES-1:0] drop;
    int unsigned      drop_cnt;

    bullet_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .tick    (tick)
    );

    assign lane_ok = fire_lane < LW'(LANES);
    // The held request is still high while ack/err shows; gating on them keeps one pulse per request.
    assign accept  = fire & lane_ok & (cooldown == '0) & ~fire_ack;
    assign reject  = fire & ~lane_ok & ~fire_ack & ~fire_err;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign ins[i] = accept & (fire_lane == LW'(i));

        bullet_lane #(
            .DEPTH  (DEPTH),
            .DIR_UP (DIR_UP)
        ) u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .tick    (tick),
            .insert  (ins[i]),
`ifdef BULLET_HIT_CLEAR_EN
            .clr     (hit_mask[i*DEPTH +: DEPTH]),
`endif
            .col     (grid[i*DEPTH +: DEPTH]),
            .dropped (drop[i])
        );
    end

    always_comb begin
        drop_cnt = 0;
        for (int i = 0; i < LANES; i++)
            drop_cnt = drop_cnt + 32'(drop[i]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cooldown    <= '0;
            fire_ack    <= 1'b0;
            fire_err    <= 1'b0;
            escaped_cnt <= '0;
        end else begin
            fire_ack <= accept;
            fire_err <= reject;
            if (accept)
                cooldown <= CD_LOAD;
            else if (tick && cooldown != '0)
                cooldown <= cooldown - CDW'(1);
            if (tick)
                escaped_cnt <= esc_sat_add(escaped_cnt, drop_cnt);
        end
    end

endmodule

// File: tb/tb_bullet_lane_array.sv
// Bench for bullet_lane_array: an upward array (COOLDOWN=3) and a downward
// array (COOLDOWN=0) checked every cycle against a distance-to-exit model.
module tb_bullet_lane_array;

    localparam int LANES = 8;
    localparam int DEPTH = 16;
    localparam int TDIV  = 4;
    localparam int LW    = $clog2(LANES) + 1;
    localparam int GW    = LANES * DEPTH;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic [1:0]    fire = '0;
    logic [LW-1:0] lane [2];

    wire  [1:0]    ack;
    wire  [1:0]    err;
    wire  [1:0]    tk;
    wire  [GW-1:0] grid [2];
    wire  [7:0]    esc [2];

`ifdef BULLET_HIT_CLEAR_EN
    logic [GW-1:0] hit_mask = '0;
    logic [GW-1:0] hit_zero = '0;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    bullet_lane_array #(.LANES(LANES), .DEPTH(DEPTH), .DIR_UP(1'b1), .TICK_DIV(TDIV), .COOLDOWN(3)) dut_up (
        .clk(clk), .reset_n(reset_n), .enable(enable), .fire(fire[0]), .fire_lane(lane[0]),
`ifdef BULLET_HIT_CLEAR_EN
        .hit_mask(hit_mask),
`endif
        .fire_ack(ack[0]), .fire_err(err[0]), .tick(tk[0]), .grid(grid[0]), .escaped_cnt(esc[0]));

    bullet_lane_array #(.LANES(LANES), .DEPTH(DEPTH), .DIR_UP(1'b0), .TICK_DIV(TDIV), .COOLDOWN(0)) dut_dn (
        .clk(clk), .reset_n(reset_n), .enable(enable), .fire(fire[1]), .fire_lane(lane[1]),
`ifdef BULLET_HIT_CLEAR_EN
        .hit_mask(hit_zero),
`endif
        .fire_ack(ack[1]), .fire_err(err[1]), .tick(tk[1]), .grid(grid[1]), .escaped_cnt(esc[1]));

    // Model: occupancy indexed by distance to the exit row (0 = about to leave).
    bit occ [2][LANES][DEPTH];
    int esc_m [2];
    int cd_m [2];
    bit ack_m [2];
    bit err_m [2];
    bit tick_m;
    int encnt;

    function automatic int cool_of(input int d);
        return (d == 0) ? 3 : 0;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int l = 0; l < LANES; l++)
                for (int k = 0; k < DEPTH; k++)
                    occ[d][l][k] = 1'b0;
            esc_m[d] = 0; cd_m[d] = 0; ack_m[d] = 1'b0; err_m[d] = 1'b0;
        end
        tick_m = 1'b0;
        encnt = 0;
    endtask

    task automatic model_edge();
        bit ok, acc, er, nt;
        int ln;
        if (!reset_n) begin
            model_reset();
            return;
        end
        for (int d = 0; d < 2; d++) begin
            ln  = int'(lane[d]);
            ok  = ln < LANES;
            acc = fire[d] && ok && cd_m[d] == 0 && !ack_m[d];
            er  = fire[d] && !ok && !ack_m[d] && !err_m[d];
`ifdef BULLET_HIT_CLEAR_EN
            if (d == 0)
                for (int l = 0; l < LANES; l++)
                    for (int r = 0; r < DEPTH; r++)
                        if (hit_mask[l*DEPTH + r]) occ[0][l][r] = 1'b0;
`endif
            if (tick_m) begin
                for (int l = 0; l < LANES; l++) begin
                    if (occ[d][l][0]) esc_m[d] = (esc_m[d] < 255) ? esc_m[d] + 1 : 255;
                    for (int k = 0; k < DEPTH - 1; k++) occ[d][l][k] = occ[d][l][k+1];
                    occ[d][l][DEPTH-1] = 1'b0;
                end
            end
            if (acc) occ[d][ln][DEPTH-1] = 1'b1;
            if (acc) cd_m[d] = cool_of(d);
            else if (tick_m && cd_m[d] > 0) cd_m[d] = cd_m[d] - 1;
            ack_m[d] = acc;
            err_m[d] = er;
        end
        nt = enable && (encnt % TDIV == TDIV - 1);
        if (enable) encnt = encnt + 1;
        tick_m = nt;
    endtask

    function automatic logic [GW-1:0] exp_grid(input int d);
        logic [GW-1:0] g = '0;
        for (int l = 0; l < LANES; l++)
            for (int k = 0; k < DEPTH; k++)
                if (occ[d][l][k]) g[l*DEPTH + ((d == 0) ? k : DEPTH - 1 - k)] = 1'b1;
        return g;
    endfunction

    task automatic chk(input string nm, input logic [GW-1:0] act, input logic [GW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out waiting (t=%0t)", nm, $time);
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("grid%0d", d), grid[d], exp_grid(d));
            chk($sformatf("esc%0d", d), GW'(esc[d]), GW'(esc_m[d]));
            chk($sformatf("ack%0d", d), GW'(ack[d]), GW'(ack_m[d]));
            chk($sformatf("err%0d", d), GW'(err[d]), GW'(err_m[d]));
            chk($sformatf("tick%0d", d), GW'(tk[d]), GW'(tick_m));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic wait_ack(input int d, input int budget, input string nm);
        bit got = 1'b0;
        for (int c = 0; c < budget && !got; c++) begin
            step();
            if (ack[d]) got = 1'b1;
        end
        if (!got) timeout_fail(nm);
    endtask

    task automatic drain(input int d, input int budget, input string nm);
        for (int c = 0; c < budget && grid[d] != '0; c++) step();
        if (grid[d] != '0) timeout_fail(nm);
    endtask

    typedef struct {
        logic [LW-1:0] lane;
        bit            exp_ack;
        bit            exp_err;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int shifts, edges, first_tick, acks, tcnt, e;
        bit prev, found;

        tbl[0] = '{4'd0,  1'b1, 1'b0};
        tbl[1] = '{4'd9,  1'b0, 1'b1};
        tbl[2] = '{4'd7,  1'b1, 1'b0};
        tbl[3] = '{4'd8,  1'b0, 1'b1};
        tbl[4] = '{4'd15, 1'b0, 1'b1};
        tbl[5] = '{4'd3,  1'b1, 1'b0};
        tbl[6] = '{4'd12, 1'b0, 1'b1};
        tbl[7] = '{4'd5,  1'b1, 1'b0};

        lane[0] = '0;
        lane[1] = '0;
        enable  = 1'b1;
        model_reset();

        // Reset state
        repeat (2) step();
        chk("rst_grid_up", grid[0], '0);
        chk("rst_esc_dn", GW'(esc[1]), '0);
        chk("rst_tick", GW'(tk), '0);
        reset_n = 1'b1;

        // Downward volleys: 8 escapes each, counter saturates at 255
        for (int v = 0; v < 40; v++) begin
            for (int l = 0; l < LANES; l++) begin
                fire[1] = 1'b1;
                lane[1] = LW'(l);
                wait_ack(1, 20, "volley_ack");
            end
            fire[1] = 1'b0;
            drain(1, 200, "volley_drain");
            if (v == 0)  chk("esc_1_volley", GW'(esc[1]), GW'(8));
            if (v == 30) chk("esc_31_volleys", GW'(esc[1]), GW'(248));
            if (v == 31) chk("esc_sat_32", GW'(esc[1]), GW'(255));
            if (v == 39) chk("esc_sat_40", GW'(esc[1]), GW'(255));
        end

        // Single-request table on the zero-cooldown array
        for (int i = 0; i < 8; i++) begin
            fire[1] = 1'b1;
            lane[1] = tbl[i].lane;
            step();
            chk($sformatf("tbl%0d_ack", i), GW'(ack[1]), GW'(tbl[i].exp_ack));
            chk($sformatf("tbl%0d_err", i), GW'(err[1]), GW'(tbl[i].exp_err));
            if (tbl[i].exp_ack)
                chk($sformatf("tbl%0d_entry", i), GW'(grid[1][int'(tbl[i].lane)*DEPTH]), GW'(1));
            fire[1] = 1'b0;
            step();
        end

        // Fresh reset: bad lane errors, valid lane acked at once, bullet run-out
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        fire[0] = 1'b1;
        lane[0] = 4'd9;
        step();
        chk("err_pulse", GW'(err[0]), GW'(1));
        chk("err_no_ack", GW'(ack[0]), GW'(0));
        chk("err_grid", grid[0], '0);
        lane[0] = 4'd2;
        step();
        chk("ack_after_err", GW'(ack[0]), GW'(1));
        chk("entry_bit47", GW'(grid[0][2*DEPTH + 15]), GW'(1));
        fire[0] = 1'b0;
        shifts = 0; edges = 2; first_tick = 0;
        for (int c = 0; c < 200 && shifts < 16; c++) begin
            prev = tk[0];
            step();
            edges++;
            if (tk[0] && first_tick == 0) first_tick = edges;
            if (prev) begin
                shifts++;
                if (shifts == 15) begin
                    chk("row0_after15", GW'(grid[0][2*DEPTH]), GW'(1));
                    chk("esc_before16", GW'(esc[0]), GW'(0));
                end
                if (shifts == 16) begin
                    chk("esc_after16", GW'(esc[0]), GW'(1));
                    chk("grid_after16", grid[0], '0);
                end
            end
        end
        if (shifts < 16) timeout_fail("runout");
        chk("first_tick_edge", GW'(first_tick), GW'(TDIV));

        // Held fire: one accept per 3 ticks
        fire[0] = 1'b1;
        lane[0] = 4'd0;
        acks = 0; tcnt = 0;
        for (int c = 0; c < 400 && acks < 5; c++) begin
            step();
            if (ack[0]) begin
                if (acks > 0) chk("cool_interval", GW'(tcnt), GW'(3));
                acks++;
                tcnt = 0;
            end
            if (tk[0]) tcnt++;
        end
        if (acks < 5) timeout_fail("held_fire");
        fire[0] = 1'b0;

        // Async reset between edges with bullets in flight
        fire[0] = 1'b1;
        lane[0] = 4'd5;
        wait_ack(0, 100, "pre_reset_ack");
        fire[0] = 1'b0;
        repeat (3) step();
        @(posedge clk);
        model_edge();
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("async_grid_up", grid[0], '0);
        chk("async_esc_up", GW'(esc[0]), '0);
        chk("async_esc_dn", GW'(esc[1]), '0);
        chk("async_tick", GW'(tk), '0);
        @(negedge clk);
        check_all();
        step();
        reset_n = 1'b1;
        first_tick = 0;
        found = 1'b0;
        for (int n = 1; n <= 10 && !found; n++) begin
            step();
            if (tk[0]) begin
                first_tick = n;
                found = 1'b1;
            end
        end
        chk("tick_after_release", GW'(first_tick), GW'(TDIV));

`ifdef BULLET_HIT_CLEAR_EN
        // Hit clear on a tick cycle removes the bullet without counting it
        fire[0] = 1'b1;
        lane[0] = 4'd3;
        wait_ack(0, 100, "hit_ack");
        fire[0] = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            step();
            if (grid[0][3*DEPTH + 10] && tk[0]) found = 1'b1;
        end
        if (!found) timeout_fail("hit_pos");
        e = int'(esc[0]);
        hit_mask[3*DEPTH + 10] = 1'b1;
        step();
        chk("hit_gone", GW'(grid[0][3*DEPTH +: DEPTH]), '0);
        hit_mask = '0;
        repeat (80) step();
        chk("hit_no_escape", GW'(esc[0]), GW'(e));
`else
        e = 0;
`endif

        // Randomized traffic on both arrays
        for (int c = 0; c < 3000; c++) begin
            enable = ($urandom % 8) != 0;
            for (int d = 0; d < 2; d++) begin
                if (fire[d] && (ack[d] || err[d])) begin
                    fire[d] = 1'b0;
                end else if (!fire[d] && ($urandom % 3) == 0) begin
                    fire[d] = 1'b1;
                    lane[d] = LW'($urandom_range(0, 11));
                end
            end
`ifdef BULLET_HIT_CLEAR_EN
            hit_mask = '0;
            if (($urandom % 6) == 0) hit_mask[$urandom_range(0, GW - 1)] = 1'b1;
`endif
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
